reg_wb_scheduler: RTL and testbench
===================================

// Module: reg_wb_scheduler
// PURPOSE
//  Scoreboard and write-port scheduler for the 32x32 register file.
//  - Tracks registers with an in-flight write.
//  - Stalls decode on RAW and WAW hazards.
//  - Shares the register file's single write port between the ALU and the long-latency unit (LU: mul/div/load).
//  - Sits between decode/execute writeback and the register file write port.
// PARAMETERS
//  DATA_W   32  register data width
//  ADDR_W   5   register address width
//  REG_NUM  32  number of architectural registers (2**ADDR_W)
// PORTS
//  clk            in   1         clock, all state updates on posedge
//  rst            in   1         asynchronous reset, active-high
//  id_valid       in   1         decode presents an instruction for issue
//  id_rs          in   ADDR_W    source register rs
//  id_rt          in   ADDR_W    source register rt
//  id_uses_rs     in   1         instruction reads rs
//  id_uses_rt     in   1         instruction reads rt
//  id_write       in   1         instruction writes id_des
//  id_des         in   ADDR_W    destination register
//  id_stall       out  1         hazard; issue refused this cycle (combinational)
//  alu_wb_valid   in   1         ALU result valid this cycle (cannot be back-pressured)
//  alu_wb_des     in   ADDR_W    ALU destination
//  alu_wb_data    in   DATA_W    ALU result
//  lu_wb_valid    in   1         LU result valid
//  lu_wb_ready    out  1         LU result accepted this cycle
//  lu_wb_des      in   ADDR_W    LU destination
//  lu_wb_data     in   DATA_W    LU result
//  w_write_reg    out  1         register-file write enable (registered)
//  reg_des        out  ADDR_W    register-file write address (registered)
//  reg_data       out  DATA_W    register-file write data (registered)
//  busy_count     out  ADDR_W+1  number of busy registers
//  quiescent      out  1         busy_count==0 and w_write_reg==0
//  wb_err         out  1         sticky: writeback to a non-busy register seen
// BEHAVIOUR
//  Reset
//   - busy[] = 0; w_write_reg = 0; reg_des = 0; reg_data = 0.
//   - busy_count = 0; wb_err = 0; quiescent = 1.
//   - Reset mid-operation discards any registered, uncommitted write.
//  Hazard detection
//   - id_stall = id_valid & ((id_uses_rs & busy[id_rs]) | (id_uses_rt & busy[id_rt]) | (id_write & busy[id_des])).
//   - busy[0] is constant 0; r0 never stalls.
//  Issue
//   - Accepted when id_valid & !id_stall.
//   - If also id_write and id_des != 0, busy[id_des] sets at that edge.
//  Arbitration
//   - Fixed priority, ALU over LU.
//   - lu_wb_ready = !alu_wb_valid (combinational).
//   - A cycle has a winner when alu_wb_valid, or when lu_wb_valid & lu_wb_ready.
//   - The winner's des/data are registered into reg_des/reg_data at the edge.
//   - w_write_reg = 1 the following cycle (latency 1), unless des == 0.
//   - LU holds des/data stable until ready; no buffering of LU data inside the block.
//  Commit
//   - busy[reg_des] clears at the edge that ends a cycle with w_write_reg=1, i.e. the edge the register file writes.
//   - Decode therefore never sees "not busy" before the data is in the file.
//  Simultaneous events
//   - Set and clear of the same index on one edge: set wins. Unreachable under the WAW stall; kept defensive.
//  busy_count
//   - Changes +1 on set only, -1 on clear only, unchanged on both or neither.
//   - Range 0..REG_NUM-1.
//  wb_err
//   - Sets when a winning writeback targets a register with busy==0 (des != 0).
//   - Cleared only by rst.
//   - The write is still performed.
// TESTING
//  1. Assert rst mid-write (w_write_reg=1) -> next edge: all outputs zero, quiescent=1, no write issued.
//  2. Issue des=5, ALU wb des=5 data=0xA5A5A5A5 the next cycle
//     -> w_write_reg=1, reg_des=5, reg_data=0xA5A5A5A5 one cycle later.
//     -> busy[5] clears at that cycle's end; an rs=5 reader stalls until then.
//  3. ALU and LU valid in the same cycle (des 3 and 4)
//     -> lu_wb_ready=0, ALU write to r3 first.
//     -> LU accepted the next cycle, r4 written one cycle after that.
//  4. Issue des=7 twice back-to-back -> second issue stalls (WAW) until r7 commits; busy_count never exceeds 1.
//  5. Issue des=0; wb des=0 -> no busy set, w_write_reg stays 0, wb_err stays 0.
//  6. LU wb des=9 with busy[9]=0 -> write performed, wb_err=1 and remains 1 until rst.

Source files
------------

// File: rtl/reg_wb_scheduler.sv
// Register-file scoreboard and single write-port scheduler.
// Tracks in-flight destinations, stalls decode on RAW/WAW hazards, and arbitrates ALU over LU writeback.
module reg_wb_scheduler #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_write,
  input  logic [ADDR_W-1:0] id_des,
  output logic              id_stall,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_des,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              lu_wb_valid,
  output logic              lu_wb_ready,
  input  logic [ADDR_W-1:0] lu_wb_des,
  input  logic [DATA_W-1:0] lu_wb_data,
  output logic              w_write_reg,
  output logic [ADDR_W-1:0] reg_des,
  output logic [DATA_W-1:0] reg_data,
  output logic [ADDR_W:0]   busy_count,
  output logic              quiescent,
  output logic              wb_err
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  logic [REG_NUM-1:0] busy;
  logic               issue_set;
  logic               win;
  logic [ADDR_W-1:0]  win_des;
  logic [DATA_W-1:0]  win_data;
  logic               win_nonzero;
  logic               cnt_inc;
  logic               cnt_dec;

  always_comb begin
    id_stall = id_valid & ((id_uses_rs & busy[id_rs]) |
                           (id_uses_rt & busy[id_rt]) |
                           (id_write   & busy[id_des]));
  end

  assign issue_set = id_valid & ~id_stall & id_write & (id_des != REG_ZERO);

  // ALU results cannot be held off, so the LU only gets the port on ALU-idle cycles.
  assign lu_wb_ready = ~alu_wb_valid;
  assign win         = alu_wb_valid | (lu_wb_valid & lu_wb_ready);
  assign win_des     = alu_wb_valid ? alu_wb_des  : lu_wb_des;
  assign win_data    = alu_wb_valid ? alu_wb_data : lu_wb_data;
  assign win_nonzero = win & (win_des != REG_ZERO);

  // Count tracks real busy transitions: a clear of an already-idle register or
  // a clear overridden by a same-index set leaves the population unchanged.
  assign cnt_inc = issue_set;
  assign cnt_dec = w_write_reg & busy[reg_des] & ~(issue_set & (id_des == reg_des));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (w_write_reg) busy[reg_des] <= 1'b0;
      if (issue_set)   busy[id_des]  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_count <= '0;
    end else if (cnt_inc & ~cnt_dec) begin
      busy_count <= busy_count + CNT_ONE;
    end else if (cnt_dec & ~cnt_inc) begin
      busy_count <= busy_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_write_reg <= 1'b0;
      reg_des     <= '0;
      reg_data    <= '0;
    end else begin
      w_write_reg <= win_nonzero;
      if (win) begin
        reg_des  <= win_des;
        reg_data <= win_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_err <= 1'b0;
    end else if (win_nonzero & ~busy[win_des]) begin
      wb_err <= 1'b1;
    end
  end

  assign quiescent = (busy_count == '0) & ~w_write_reg;

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Bench for reg_wb_scheduler: directed scenarios plus randomized traffic
// checked cycle by cycle against an array-based model of the scoreboard rules.
module tb_reg_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt, id_write;
  logic [4:0]  id_rs, id_rt, id_des;
  logic        id_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_des;
  logic [31:0] alu_wb_data;
  logic        lu_wb_valid, lu_wb_ready;
  logic [4:0]  lu_wb_des;
  logic [31:0] lu_wb_data;
  logic        w_write_reg;
  logic [4:0]  reg_des;
  logic [31:0] reg_data;
  logic [5:0]  busy_count;
  logic        quiescent, wb_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          mb[32];
  bit          m_w;
  logic [4:0]  m_des;
  logic [31:0] m_data;
  bit          m_err;

  always #5 clk = ~clk;

  reg_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_write(id_write), .id_des(id_des), .id_stall(id_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_des(alu_wb_des), .alu_wb_data(alu_wb_data),
    .lu_wb_valid(lu_wb_valid), .lu_wb_ready(lu_wb_ready),
    .lu_wb_des(lu_wb_des), .lu_wb_data(lu_wb_data),
    .w_write_reg(w_write_reg), .reg_des(reg_des), .reg_data(reg_data),
    .busy_count(busy_count), .quiescent(quiescent), .wb_err(wb_err)
  );

  task automatic idle_inputs();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_write = 0;
    id_rs = 0; id_rt = 0; id_des = 0;
    alu_wb_valid = 0; alu_wb_des = 0; alu_wb_data = 0;
    lu_wb_valid = 0; lu_wb_des = 0; lu_wb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();
  endtask

  task automatic issue(input logic [4:0] des);
    id_valid = 1; id_write = 1; id_des = des;
  endtask

  task automatic test_reset();
    do_reset();
    issue(5);
    tick();
    idle_inputs();
    alu_wb_valid = 1; alu_wb_des = 5; alu_wb_data = 32'h1234_5678;
    tick();
    idle_inputs();
    #1;
    checks++; if (w_write_reg !== 1'b1) begin errors++; $display("FAIL rst_pre_w got %0b exp 1", w_write_reg); end
    rst = 1;
    #1;
    checks++; if (w_write_reg !== 1'b0) begin errors++; $display("FAIL rst_w got %0b exp 0", w_write_reg); end
    checks++; if (reg_des !== 5'd0) begin errors++; $display("FAIL rst_des got %0d exp 0", reg_des); end
    checks++; if (reg_data !== 32'd0) begin errors++; $display("FAIL rst_data got %0h exp 0", reg_data); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", busy_count); end
    checks++; if (quiescent !== 1'b1) begin errors++; $display("FAIL rst_quiescent got %0b exp 1", quiescent); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", wb_err); end
    tick();
    rst = 0;
    tick();
    id_valid = 1; id_uses_rs = 1; id_rs = 5;
    #1;
    checks++; if (w_write_reg !== 1'b0) begin errors++; $display("FAIL rst_after_w got %0b exp 0", w_write_reg); end
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rst_after_stall got %0b exp 0", id_stall); end
    idle_inputs();
  endtask

  task automatic test_alu_commit();
    do_reset();
    issue(5);
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL alu_issue_stall got %0b exp 0", id_stall); end
    tick();
    idle_inputs();
    alu_wb_valid = 1; alu_wb_des = 5; alu_wb_data = 32'hA5A5_A5A5;
    id_valid = 1; id_uses_rs = 1; id_rs = 5;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL alu_raw_b got %0b exp 1", id_stall); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL alu_count got %0d exp 1", busy_count); end
    checks++; if (w_write_reg !== 1'b0) begin errors++; $display("FAIL alu_w_early got %0b exp 0", w_write_reg); end
    tick();
    alu_wb_valid = 0;
    #1;
    checks++; if (w_write_reg !== 1'b1) begin errors++; $display("FAIL alu_w got %0b exp 1", w_write_reg); end
    checks++; if (reg_des !== 5'd5) begin errors++; $display("FAIL alu_des got %0d exp 5", reg_des); end
    checks++; if (reg_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL alu_data got %0h exp a5a5a5a5", reg_data); end
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL alu_raw_c got %0b exp 1", id_stall); end
    tick();
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL alu_raw_d got %0b exp 0", id_stall); end
    checks++; if (w_write_reg !== 1'b0) begin errors++; $display("FAIL alu_w_end got %0b exp 0", w_write_reg); end
    checks++; if (quiescent !== 1'b1) begin errors++; $display("FAIL alu_quiescent got %0b exp 1", quiescent); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL alu_err got %0b exp 0", wb_err); end
    idle_inputs();
  endtask

  task automatic test_arbitration();
    do_reset();
    issue(3); tick();
    issue(4); tick();
    idle_inputs();
    alu_wb_valid = 1; alu_wb_des = 3; alu_wb_data = 32'h0000_0333;
    lu_wb_valid = 1;  lu_wb_des = 4;  lu_wb_data = 32'h0000_0444;
    #1;
    checks++; if (lu_wb_ready !== 1'b0) begin errors++; $display("FAIL arb_ready_a got %0b exp 0", lu_wb_ready); end
    checks++; if (busy_count !== 6'd2) begin errors++; $display("FAIL arb_count got %0d exp 2", busy_count); end
    tick();
    alu_wb_valid = 0;
    #1;
    checks++; if (lu_wb_ready !== 1'b1) begin errors++; $display("FAIL arb_ready_b got %0b exp 1", lu_wb_ready); end
    checks++; if (w_write_reg !== 1'b1 || reg_des !== 5'd3 || reg_data !== 32'h333) begin
      errors++; $display("FAIL arb_first got w=%0b des=%0d data=%0h exp w=1 des=3 data=333", w_write_reg, reg_des, reg_data); end
    tick();
    lu_wb_valid = 0;
    #1;
    checks++; if (w_write_reg !== 1'b1 || reg_des !== 5'd4 || reg_data !== 32'h444) begin
      errors++; $display("FAIL arb_second got w=%0b des=%0d data=%0h exp w=1 des=4 data=444", w_write_reg, reg_des, reg_data); end
    tick();
    checks++; if (busy_count !== 6'd0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL arb_end got count=%0d err=%0b exp count=0 err=0", busy_count, wb_err); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(7);
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL waw_first got %0b exp 0", id_stall); end
    tick();
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL waw_second got %0b exp 1", id_stall); end
    alu_wb_valid = 1; alu_wb_des = 7; alu_wb_data = 32'h77;
    tick();
    alu_wb_valid = 0;
    #1;
    checks++; if (id_stall !== 1'b1 || w_write_reg !== 1'b1) begin
      errors++; $display("FAIL waw_commit got stall=%0b w=%0b exp stall=1 w=1", id_stall, w_write_reg); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL waw_count got %0d exp 1", busy_count); end
    tick();
    #1;
    checks++; if (id_stall !== 1'b0 || busy_count !== 6'd0) begin
      errors++; $display("FAIL waw_release got stall=%0b count=%0d exp stall=0 count=0", id_stall, busy_count); end
    tick();
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL waw_reissue got %0d exp 1", busy_count); end
    alu_wb_valid = 1; alu_wb_des = 7; alu_wb_data = 32'h78;
    tick();
    alu_wb_valid = 0;
    tick();
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL waw_end got %0d exp 0", busy_count); end
    idle_inputs();
  endtask

  task automatic test_r0();
    do_reset();
    issue(0);
    id_uses_rs = 1; id_rs = 0;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0b exp 0", id_stall); end
    tick();
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL r0_count got %0d exp 0", busy_count); end
    alu_wb_valid = 1; alu_wb_des = 0; alu_wb_data = 32'hDEAD_BEEF;
    tick();
    alu_wb_valid = 0;
    #1;
    checks++; if (w_write_reg !== 1'b0 || wb_err !== 1'b0 || quiescent !== 1'b1) begin
      errors++; $display("FAIL r0_wb got w=%0b err=%0b q=%0b exp w=0 err=0 q=1", w_write_reg, wb_err, quiescent); end
    idle_inputs();
  endtask

  task automatic test_wb_err();
    do_reset();
    lu_wb_valid = 1; lu_wb_des = 9; lu_wb_data = 32'h9999;
    #1;
    checks++; if (lu_wb_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %0b exp 1", lu_wb_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (w_write_reg !== 1'b1 || reg_des !== 5'd9 || reg_data !== 32'h9999) begin
      errors++; $display("FAIL err_write got w=%0b des=%0d data=%0h exp w=1 des=9 data=9999", w_write_reg, reg_des, reg_data); end
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %0b exp 1", wb_err); end
    repeat (4) tick();
    checks++; if (wb_err !== 1'b1 || busy_count !== 6'd0) begin
      errors++; $display("FAIL err_sticky got err=%0b count=%0d exp err=1 count=0", wb_err, busy_count); end
    do_reset();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", wb_err); end
  endtask

  function automatic logic [4:0] pick_des();
    int n = 0;
    logic [4:0] cand[$];
    for (int i = 0; i < 32; i++) if (mb[i]) cand.push_back(5'(i));
    n = cand.size();
    if (n == 0 || $urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return cand[$urandom_range(0, n - 1)];
  endfunction

  task automatic test_random();
    bit lu_hold = 0;
    bit e_stall, e_ready, win, set;
    logic [4:0] wdes;
    logic [31:0] wdata;
    int pop;
    do_reset();
    for (int i = 0; i < 32; i++) mb[i] = 0;
    m_w = 0; m_des = 0; m_data = 0; m_err = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      id_valid = ($urandom_range(0, 1) == 1);
      id_uses_rs = ($urandom_range(0, 1) == 1); id_rs = 5'($urandom_range(0, 31));
      id_uses_rt = ($urandom_range(0, 1) == 1); id_rt = 5'($urandom_range(0, 31));
      id_write = ($urandom_range(0, 3) != 0);   id_des = 5'($urandom_range(0, 31));
      alu_wb_valid = ($urandom_range(0, 3) == 0);
      alu_wb_des = pick_des(); alu_wb_data = $urandom;
      if (!lu_hold) begin
        lu_wb_valid = ($urandom_range(0, 2) == 0);
        lu_wb_des = pick_des(); lu_wb_data = $urandom;
      end
      #1;
      e_stall = id_valid && ((id_uses_rs && mb[id_rs]) || (id_uses_rt && mb[id_rt]) || (id_write && mb[id_des]));
      e_ready = !alu_wb_valid;
      pop = 0;
      for (int i = 0; i < 32; i++) pop += int'(mb[i]);
      checks++; if (id_stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %0b exp %0b", cyc, id_stall, e_stall); end
      checks++; if (lu_wb_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b exp %0b", cyc, lu_wb_ready, e_ready); end
      checks++; if (w_write_reg !== m_w) begin errors++; $display("FAIL rnd_w cyc %0d got %0b exp %0b", cyc, w_write_reg, m_w); end
      checks++; if (reg_des !== m_des || reg_data !== m_data) begin
        errors++; $display("FAIL rnd_port cyc %0d got %0d/%0h exp %0d/%0h", cyc, reg_des, reg_data, m_des, m_data); end
      checks++; if (busy_count !== 6'(pop)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, busy_count, pop); end
      checks++; if (quiescent !== (pop == 0 && !m_w)) begin errors++; $display("FAIL rnd_quiescent cyc %0d got %0b", cyc, quiescent); end
      checks++; if (wb_err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %0b exp %0b", cyc, wb_err, m_err); end
      set = id_valid && !e_stall && id_write && id_des != 0;
      win = alu_wb_valid || lu_wb_valid;
      wdes = alu_wb_valid ? alu_wb_des : lu_wb_des;
      wdata = alu_wb_valid ? alu_wb_data : lu_wb_data;
      if (win && wdes != 0 && !mb[wdes]) m_err = 1;
      if (m_w) mb[m_des] = 0;
      if (set) mb[id_des] = 1;
      m_w = win && wdes != 0;
      if (win) begin m_des = wdes; m_data = wdata; end
      lu_hold = lu_wb_valid && !e_ready;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    checks++; if (quiescent !== 1'b1 || w_write_reg !== 1'b0 || busy_count !== 6'd0) begin
      errors++; $display("FAIL init_reset got q=%0b w=%0b count=%0d exp q=1 w=0 count=0", quiescent, w_write_reg, busy_count); end
    test_reset();
    test_alu_commit();
    test_arbitration();
    test_back_to_back();
    test_r0();
    test_wb_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
